uart_tx_scheduler: RTL

- Round-robin scheduler that shares one UART transmitter among N_REQ byte producers.
- Accepts a byte request from each producer and grants one at a time.
- For the granted producer: latches its byte and a snapshot of the frame configuration (dnum, snum, par, bd_rate), issues a one-cycle start to the transmitter, then holds configuration stable until the transmitter reports frame completion or a timeout fires.
- Sits between the host-side producers and the UART transmitter, mirroring the configuration encoding the UART receiver uses.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 18 +
 rtl/uart_tx_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, scheduler state and latched frame configuration.
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] BAUD_9600 = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_57600 = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_START, S_WAIT_DONE} sched_state_e;
  typedef struct packed {
    logic dnum;
    logic snum;
    logic [1:0] par;
    logic [1:0] bd_rate;
  } frame_cfg_t;
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx
);
  logic [N-1:0] hi, src;
  always_comb begin
    hi = req & ~((N'(1) << ptr) - N'(1));
    src = |hi ? hi : req;
    gnt = src & (~src + N'(1));
    idx = '0;
    for (int i = 0; i < N; i++) idx = gnt[i] ? 3'(i) : idx;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among N_REQ byte producers.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TO_W = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic             cfg_dnum,
  input  logic             cfg_snum,
  input  logic [1:0]       cfg_par,
  input  logic [1:0]       cfg_bd_rate,
  input  logic             tx_done,
  output logic [N_REQ-1:0] gnt,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             tx_dnum,
  output logic             tx_snum,
  output logic [1:0]       tx_par,
  output logic [1:0]       tx_bd_rate,
  output logic             busy,
  output logic [2:0]       owner,
  output logic             timeout_err
);
  sched_state_e state_q, state_d;
  logic [2:0] ptr_q, ptr_d, owner_q, owner_d, arb_idx;
  logic [7:0] data_q, data_d, byte_sel;
  frame_cfg_t cfg_q, cfg_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] arb_gnt;
  logic to_hit;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(req), .ptr(ptr_q), .gnt(arb_gnt), .idx(arb_idx));
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < N_REQ; i++) byte_sel |= arb_gnt[i] ? req_data[8*i +: 8] : 8'h00;
  end
  assign to_hit = cnt_q == TO_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    data_d = data_q;
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: if (|req) begin
        state_d = S_GRANT;
        owner_d = arb_idx;
        data_d = {cfg_dnum & byte_sel[7], byte_sel[6:0]};
        cfg_d = '{dnum: cfg_dnum, snum: cfg_snum, par: cfg_par, bd_rate: cfg_bd_rate};
      end
      S_GRANT: state_d = S_START;
      S_START: begin
        state_d = S_WAIT_DONE;
        cnt_d = '0;
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_done || to_hit) begin
          state_d = S_IDLE;
          ptr_d = owner_q == 3'(N_REQ - 1) ? 3'd0 : owner_q + 3'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      data_q <= '0;
      cfg_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      data_q <= data_d;
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
    end
  assign gnt = state_q == S_GRANT ? N_REQ'(1) << owner_q : '0;
  assign tx_start = state_q == S_START;
  assign busy = state_q != S_IDLE;
  assign timeout_err = state_q == S_WAIT_DONE && !tx_done && to_hit;
  assign owner = owner_q;
  assign tx_data = data_q;
  assign tx_dnum = cfg_q.dnum;
  assign tx_snum = cfg_q.snum;
  assign tx_par = cfg_q.par;
  assign tx_bd_rate = cfg_q.bd_rate;
endmodule
